mant_align_shifter: RTL and testbench

Iterative right-shifter that aligns the smaller significand to the larger operand's exponent in the FP add/subtract datapath. It consumes the registered exponent difference from the exponent add/subtract stage and the swapped-smaller significand. It produces the significand extended with guard, round and sticky bits for the mantissa adder. The shift takes one logarithmic shift step per cycle under a small FSM with a start/ready handshake.

---
 rtl/fpu_addsub_pkg.sv | 33 +++
 rtl/mant_align_shifter_sticky_rshift_step.sv | 36 +++
 rtl/mant_align_shifter.sv | 119 +++++++++++
 tb/tb_mant_align_shifter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_addsub_pkg.sv
// Shared constants, helpers and FSM encoding for the FP add/subtract datapath.
// Contents: default significand/exponent widths, derived aligned width (XW),
// shift step count (LS), clog2 helpers and the alignment FSM state type.
package fpu_addsub_pkg;

    localparam int unsigned SW_DEF = 24;
    localparam int unsigned EW_DEF = 8;

    // Ceiling log2 usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index width for selecting one of n bits; never narrower than 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    localparam int unsigned XW_DEF = SW_DEF + 3;
    localparam int unsigned LS_DEF = clog2(XW_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/mant_align_shifter_sticky_rshift_step.sv
// One logarithmic right-shift step with sticky folding.
// Ports: x   - working value {significand, G, R, S}
//        b   - step index; shift distance is 2^b
//        en  - apply this step (the shift-amount bit for b)
//        y   - result; bit 0 is the OR of every bit that moved through or past it
module sticky_rshift_step
    import fpu_addsub_pkg::*;
#(
    parameter int unsigned XW = XW_DEF,
    parameter int unsigned LS = LS_DEF,
    localparam int unsigned KW = idx_width(LS)
) (
    input  logic [XW-1:0] x,
    input  logic [KW-1:0] b,
    input  logic          en,
    output logic [XW-1:0] y
);

    logic [31:0]   s;
    logic [XW-1:0] shifted;
    logic [XW-1:0] mask;
    logic          sticky;

    // Bits x[s:0] all collapse into position 0, including the old sticky.
    always_comb begin
        s       = 32'(1) << b;
        shifted = x >> s;
        mask    = ~({XW{1'b1}} << (s + 32'(1)));
        sticky  = |(x & mask);
        y       = x;
        if (en) begin
            y = {shifted[XW-1:1], sticky};
        end
    end

endmodule

// File: rtl/mant_align_shifter.sv
// Iterative significand alignment shifter for the FP add/subtract datapath.
// Shifts the smaller significand right by the exponent difference, one
// power-of-two step per cycle, producing {significand, G, R, S}.
// Ports: clk, rst (sync, active-high)
//        start_i     - request; accepted in IDLE or DONE
//        Exp_Diff_i  - unsigned exponent difference, captured with start_i
//        Data_M_i    - significand to align, captured with start_i
//        busy_o      - high while shifting
//        ready_o     - one-cycle pulse, Data_Shft_o valid
//        Data_Shft_o - aligned result, held until the next completion
module mant_align_shifter
    import fpu_addsub_pkg::*;
#(
    parameter int unsigned SW = SW_DEF,
    parameter int unsigned EW = EW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [EW-1:0]   Exp_Diff_i,
    input  logic [SW-1:0]   Data_M_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [SW+2:0]   Data_Shft_o
);

    localparam int unsigned XW = SW + 3;
    localparam int unsigned LS = clog2(XW);
    localparam int unsigned KW = idx_width(LS);

    align_state_t  state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [LS-1:0] amt_q, amt_d;
    logic [KW-1:0] k_q, k_d;
    logic [XW-1:0] res_d;
    logic [XW-1:0] x_step;
    logic [LS-1:0] amt_sat;

    // Any difference of XW-1 or more leaves only the sticky bit.
    always_comb begin
        amt_sat = LS'(Exp_Diff_i);
        if (32'(Exp_Diff_i) >= XW - 1) begin
            amt_sat = LS'(XW - 1);
        end
    end

    sticky_rshift_step #(
        .XW (XW),
        .LS (LS)
    ) u_step (
        .x  (x_q),
        .b  (k_q),
        .en (amt_q[k_q]),
        .y  (x_step)
    );

    // Next-state and datapath control; steps run MSB-first from k = LS-1.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        amt_d   = amt_q;
        k_d     = k_q;
        res_d   = Data_Shft_o;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d     = {Data_M_i, 3'b000};
                    amt_d   = amt_sat;
                    k_d     = KW'(LS - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                x_d = x_step;
                if (k_q == '0) begin
                    res_d   = x_step;
                    state_d = DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                if (start_i) begin
                    x_d     = {Data_M_i, 3'b000};
                    amt_d   = amt_sat;
                    k_d     = KW'(LS - 1);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            amt_q       <= '0;
            k_q         <= '0;
            busy_o      <= 1'b0;
            ready_o     <= 1'b0;
            Data_Shft_o <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            amt_q       <= amt_d;
            k_q         <= k_d;
            busy_o      <= (state_d == SHIFT);
            ready_o     <= (state_d == DONE);
            Data_Shft_o <= res_d;
        end
    end

endmodule

// File: tb/tb_mant_align_shifter.sv
// Scoreboard bench for mant_align_shifter at default widths.
module tb_mant_align_shifter;

    localparam int unsigned SW = 24;
    localparam int unsigned EW = 8;
    localparam int unsigned XW = SW + 3;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [EW-1:0] Exp_Diff_i;
    logic [SW-1:0] Data_M_i;
    logic          busy_o;
    logic          ready_o;
    logic [XW-1:0] Data_Shft_o;

    int n_vec = 0;
    int n_err = 0;
    logic [XW-1:0] exp_q[$];

    mant_align_shifter #(.SW(SW), .EW(EW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .Exp_Diff_i  (Exp_Diff_i),
        .Data_M_i    (Data_M_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .Data_Shft_o (Data_Shft_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per ready pulse, also checks pulse width and busy length.
    int   busy_run = 0;
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_run   = 0;
            prev_ready = 1'b0;
        end else begin
            if (ready_o) begin
                check("ready_single_cycle", 32'(prev_ready), 32'd0);
                check("busy_cycles", 32'(busy_run), 32'd5);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ready: got data %h with nothing pending", Data_Shft_o);
                end else begin
                    check("data_shft", 32'(Data_Shft_o), 32'(exp_q.pop_front()));
                end
                busy_run = 0;
            end else if (busy_o) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
            prev_ready = ready_o;
        end
    end

    task automatic issue(input logic [SW-1:0] d, input logic [EW-1:0] e);
        @(posedge clk);
        #1;
        start_i    = 1'b1;
        Data_M_i   = d;
        Exp_Diff_i = e;
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        Data_M_i   = 24'h5A5A5A;
        Exp_Diff_i = 8'h77;
    endtask

    task automatic wait_ready();
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ready_o && cnt < 20);
        if (!ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: no ready within %0d cycles", cnt);
        end
    endtask

    task automatic run(input logic [SW-1:0] d, input logic [EW-1:0] e, input logic [XW-1:0] req);
        exp_q.push_back(req);
        issue(d, e);
        wait_ready();
    endtask

    initial begin
        int gap;
        rst        = 1'b1;
        start_i    = 1'b0;
        Data_M_i   = '0;
        Exp_Diff_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_data", 32'(Data_Shft_o), 32'd0);
        rst = 1'b0;

        // Directed alignments
        run(24'h800000, 8'd0,   27'h4000000);
        run(24'h800000, 8'd1,   27'h2000000);
        run(24'hC00003, 8'd4,   27'h0600001);
        run(24'h800001, 8'd26,  27'h0000001);
        run(24'h800001, 8'd255, 27'h0000001);
        run(24'hFFFFFF, 8'd0,   27'h7FFFFF8);
        run(24'h000001, 8'd4,   27'h0000001);
        run(24'hFFFFFF, 8'd3,   27'h0FFFFFF);

        // start_i during SHIFT is ignored
        exp_q.push_back(27'h1000000);
        issue(24'h800000, 8'd2);
        @(posedge clk);
        #1;
        start_i    = 1'b1;
        Data_M_i   = 24'h123456;
        Exp_Diff_i = 8'd0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_ready();
        repeat (8) @(negedge clk);

        // start_i held high through DONE: back-to-back operations
        @(posedge clk);
        #1;
        start_i    = 1'b1;
        Data_M_i   = 24'h800000;
        Exp_Diff_i = 8'd0;
        exp_q.push_back(27'h4000000);
        exp_q.push_back(27'h0600001);
        @(posedge clk);
        #1;
        Data_M_i   = 24'hC00003;
        Exp_Diff_i = 8'd4;
        wait_ready();
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!ready_o && gap < 20);
        start_i = 1'b0;
        check("b2b_ready_gap", 32'(gap), 32'd6);
        repeat (3) @(negedge clk);

        // Reset in the third SHIFT cycle
        issue(24'hFFFFFF, 8'd5);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd0);
        check("midrst_data", 32'(Data_Shft_o), 32'd0);
        #1;
        rst = 1'b0;
        run(24'h800000, 8'd1, 27'h2000000);
        repeat (8) @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
